// File: rtl/check_monitor_pkg.sv
// Shared types for the check monitor: severity and run-state encodings,
// run-end cause priority, and a width helper for channel indices.
package check_monitor_pkg;

    typedef enum logic [1:0] {
        SEV_INFO  = 2'd0,
        SEV_WARN  = 2'd1,
        SEV_ERROR = 2'd2,
        SEV_FATAL = 2'd3
    } sev_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    // Run-end causes, listed in decreasing priority: a fatal failure or the
    // error limit beats i_done, and i_done beats the watchdog.
    typedef enum logic [2:0] {
        END_NONE      = 3'd0,
        END_FATAL     = 3'd1,
        END_ERR_LIMIT = 3'd2,
        END_DONE_PASS = 3'd3,
        END_DONE_FAIL = 3'd4,
        END_TIMEOUT   = 3'd5
    } end_cause_e;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/check_sat_counter.sv
// Saturating failure counter: adds the popcount of a masked failure vector
// each enabled cycle, clamps at all-ones, and clears synchronously.
module check_sat_counter
    import check_monitor_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic [IN_W-1:0]      i_vec,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic [CNT_WIDTH-1:0] o_cnt_next
);

    localparam int POP_W = $clog2(IN_W + 1);
    localparam int SUM_W = ((CNT_WIDTH > POP_W) ? CNT_WIDTH : POP_W) + 1;

    logic [POP_W-1:0]     pop;
    logic [SUM_W-1:0]     sum;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        pop = '0;
        for (int i = 0; i < IN_W; i++) begin
            pop = pop + POP_W'(i_vec[i]);
        end
        sum   = SUM_W'(cnt_q) + SUM_W'(pop);
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = (|sum[SUM_W-1:CNT_WIDTH]) ? '1 : sum[CNT_WIDTH-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments only; reset is
    // synchronous and active-low.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt      = cnt_q;
    assign o_cnt_next = cnt_d;

endmodule

// File: rtl/check_monitor.sv
// Self-checking monitor: counts per-severity check failures, latches the
// first failing channel, and runs the IDLE/RUN/PASS/FAIL decision machine.
module check_monitor
    import check_monitor_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16,
    parameter int ERR_LIMIT = 1,
    parameter int TIMEOUT   = 1000,
    parameter int TO_WIDTH  = $clog2(TIMEOUT + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_clear,
    input  logic                         i_done,
    input  logic [NUM_CH-1:0]            i_chk_valid,
    input  logic [NUM_CH-1:0]            i_chk_pass,
    input  logic [2*NUM_CH-1:0]          i_chk_sev,
    output logic [1:0]                   o_state,
    output logic [CNT_WIDTH-1:0]         o_info_cnt,
    output logic [CNT_WIDTH-1:0]         o_warn_cnt,
    output logic [CNT_WIDTH-1:0]         o_err_cnt,
    output logic                         o_fatal,
    output logic                         o_timeout,
    output logic [idx_width(NUM_CH)-1:0] o_first_ch,
    output logic                         o_first_vld,
    output logic                         o_finish
);

    localparam int FCH_W = idx_width(NUM_CH);
    localparam int WD_W  = (TO_WIDTH < 1) ? 1 : TO_WIDTH;

    state_e           state_q, state_d;
    end_cause_e       cause;
    logic             run, start_clr, timeout_hit;
    logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
    logic             fatal_q, fatal_d;
    logic             timeout_q, timeout_d;
    logic             finish_q, finish_d;
    logic             first_vld_q, first_vld_d;
    logic [FCH_W-1:0] first_ch_q, first_ch_d, first_idx;

    logic [NUM_CH-1:0] fail_vec, info_vec, warn_vec, err_vec, fatal_vec;
    logic [CNT_WIDTH-1:0] info_next, warn_next, err_next;
    logic              next_sink;

    assign run       = (state_q == ST_RUN);
    assign start_clr = (state_q == ST_IDLE) && i_start;

    // Split failing channels by severity; only failures in RUN are counted.
    always_comb begin
        fail_vec  = i_chk_valid & ~i_chk_pass;
        info_vec  = '0;
        warn_vec  = '0;
        err_vec   = '0;
        fatal_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (sev_e'(i_chk_sev[2*c +: 2]))
                SEV_INFO:  info_vec[c]  = fail_vec[c];
                SEV_WARN:  warn_vec[c]  = fail_vec[c];
                SEV_ERROR: err_vec[c]   = fail_vec[c];
                default:   fatal_vec[c] = fail_vec[c];
            endcase
        end
    end

    check_sat_counter #(.IN_W(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) u_info_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_clear(start_clr), .i_en(run),
        .i_vec(info_vec), .o_cnt(o_info_cnt), .o_cnt_next(info_next)
    );

    check_sat_counter #(.IN_W(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) u_warn_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_clear(start_clr), .i_en(run),
        .i_vec(warn_vec), .o_cnt(o_warn_cnt), .o_cnt_next(warn_next)
    );

    check_sat_counter #(.IN_W(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_clear(start_clr), .i_en(run),
        .i_vec(err_vec), .o_cnt(o_err_cnt), .o_cnt_next(err_next)
    );

    // Only the error count feeds the decision; the other look-aheads are unused.
    assign next_sink = ^{info_next, warn_next};

    // wd_inc is the number of the current RUN cycle (1 in the first one).
    assign wd_inc      = wd_q + WD_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (wd_inc == WD_W'(TIMEOUT));

    always_comb begin
        cause = END_NONE;
        if (run) begin
            if (|fatal_vec) begin
                cause = END_FATAL;
            end else if (err_next >= CNT_WIDTH'(ERR_LIMIT)) begin
                cause = END_ERR_LIMIT;
            end else if (i_done) begin
                cause = (err_next == '0) ? END_DONE_PASS : END_DONE_FAIL;
            end else if (timeout_hit) begin
                cause = END_TIMEOUT;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_RUN;
            ST_RUN: begin
                if (cause == END_DONE_PASS) begin
                    state_d = ST_PASS;
                end else if (cause != END_NONE) begin
                    state_d = ST_FAIL;
                end
            end
            default: if (i_clear) state_d = ST_IDLE;
        endcase
    end

    // Output / flag next values
    always_comb begin
        finish_d    = run && (cause != END_NONE);
        wd_d        = wd_q;
        fatal_d     = fatal_q;
        timeout_d   = timeout_q;
        first_vld_d = first_vld_q;
        first_ch_d  = first_ch_q;
        first_idx   = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (fail_vec[c]) first_idx = FCH_W'(c);
        end
        if (start_clr) begin
            wd_d        = '0;
            fatal_d     = 1'b0;
            timeout_d   = 1'b0;
            first_vld_d = 1'b0;
            first_ch_d  = '0;
        end else if (run) begin
            wd_d = wd_inc;
            if (|fatal_vec) fatal_d = 1'b1;
            if (cause == END_TIMEOUT) timeout_d = 1'b1;
            if (!first_vld_q && (|fail_vec)) begin
                first_vld_d = 1'b1;
                first_ch_d  = first_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wd_q        <= '0;
            fatal_q     <= 1'b0;
            timeout_q   <= 1'b0;
            finish_q    <= 1'b0;
            first_vld_q <= 1'b0;
            first_ch_q  <= '0;
        end else begin
            wd_q        <= wd_d;
            fatal_q     <= fatal_d;
            timeout_q   <= timeout_d;
            finish_q    <= finish_d;
            first_vld_q <= first_vld_d;
            first_ch_q  <= first_ch_d;
        end
    end

    assign o_state     = state_q;
    assign o_fatal     = fatal_q;
    assign o_timeout   = timeout_q;
    assign o_finish    = finish_q;
    assign o_first_vld = first_vld_q;
    assign o_first_ch  = first_ch_q;

endmodule

// File: tb/tb_check_monitor.sv
// Table-driven bench for check_monitor with a scoreboard queue of expected
// post-edge outputs, plus a bounded-wait watchdog latency sequence.
module tb_check_monitor;
    import check_monitor_pkg::*;

    localparam int NCH  = 4;
    localparam int CW   = 2;
    localparam int ELIM = 3;
    localparam int TO   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, clear, done;
    logic [3:0]    valid, pass;
    logic [7:0]    sev;
    logic [1:0]    state;
    logic [CW-1:0] info, warn, err;
    logic          fatal, tout, fvld, fin;
    logic [1:0]    fch;

    check_monitor #(
        .NUM_CH(NCH), .CNT_WIDTH(CW), .ERR_LIMIT(ELIM), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
        .i_done(done), .i_chk_valid(valid), .i_chk_pass(pass),
        .i_chk_sev(sev), .o_state(state), .o_info_cnt(info),
        .o_warn_cnt(warn), .o_err_cnt(err), .o_fatal(fatal),
        .o_timeout(tout), .o_first_ch(fch), .o_first_vld(fvld),
        .o_finish(fin)
    );

    typedef struct {
        logic       rst, start, clear, done;
        logic [3:0] valid, pass;
        logic [7:0] sev;
        logic [1:0] st, info, warn, err;
        logic       fatal, to;
        logic [1:0] fch;
        logic       fvld, fin;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, s, c, d, input logic [3:0] v, p, input logic [7:0] sv,
                       input logic [1:0] st, i, w, e, input logic f, t,
                       input logic [1:0] fc, input logic fv, fn);
        vec_t x;
        x.rst = r; x.start = s; x.clear = c; x.done = d;
        x.valid = v; x.pass = p; x.sev = sv;
        x.st = st; x.info = i; x.warn = w; x.err = e;
        x.fatal = f; x.to = t; x.fch = fc; x.fvld = fv; x.fin = fn;
        vecs.push_back(x);
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; start = v.start; clear = v.clear; done = v.done;
        valid = v.valid; pass = v.pass; sev = v.sev;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d state", idx), 32'(state), 32'(e.st));
        check($sformatf("v%0d info", idx), 32'(info), 32'(e.info));
        check($sformatf("v%0d warn", idx), 32'(warn), 32'(e.warn));
        check($sformatf("v%0d err", idx), 32'(err), 32'(e.err));
        check($sformatf("v%0d fatal", idx), 32'(fatal), 32'(e.fatal));
        check($sformatf("v%0d timeout", idx), 32'(tout), 32'(e.to));
        check($sformatf("v%0d first_vld", idx), 32'(fvld), 32'(e.fvld));
        if (e.fvld) check($sformatf("v%0d first_ch", idx), 32'(fch), 32'(e.fch));
        check($sformatf("v%0d finish", idx), 32'(fin), 32'(e.fin));
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; clear = 1'b0; done = 1'b0;
        valid = '0; pass = '0; sev = '0;
        repeat (2) @(posedge clk);

        // Reset state
        add(0,0,0,0,4'h0,4'h0,8'h00, 0,0,0,0,0,0,0,0,0);
        // Warn on ch1 + info on ch3, done two cycles later -> PASS
        add(1,1,0,0,4'h0,4'h0,8'h00, 1,0,0,0,0,0,0,0,0);
        add(1,0,0,0,4'hA,4'h5,8'h04, 1,1,1,0,0,0,1,1,0);
        add(1,0,0,0,4'h0,4'h0,8'h00, 1,1,1,0,0,0,1,1,0);
        add(1,0,0,1,4'h0,4'h0,8'h00, 2,1,1,0,0,0,1,1,1);
        add(1,0,0,0,4'h0,4'h0,8'h00, 2,1,1,0,0,0,1,1,0);
        // Failures and i_start in PASS ignored; clear; failures in IDLE ignored
        add(1,0,0,0,4'hF,4'h0,8'hAA, 2,1,1,0,0,0,1,1,0);
        add(1,1,0,0,4'h0,4'h0,8'h00, 2,1,1,0,0,0,1,1,0);
        add(1,0,1,0,4'h0,4'h0,8'h00, 0,1,1,0,0,0,1,1,0);
        add(1,0,0,0,4'hF,4'h0,8'hFF, 0,1,1,0,0,0,1,1,0);
        // Error limit: ch0+ch2 then ch1 -> err=3, FAIL
        add(1,1,0,0,4'h0,4'h0,8'h00, 1,0,0,0,0,0,0,0,0);
        add(1,0,0,0,4'h5,4'h0,8'h22, 1,0,0,2,0,0,0,1,0);
        add(1,0,0,0,4'h2,4'h0,8'h08, 3,0,0,3,0,0,0,1,1);
        add(1,0,0,0,4'h0,4'h0,8'h00, 3,0,0,3,0,0,0,1,0);
        add(1,0,1,0,4'h0,4'h0,8'h00, 0,0,0,3,0,0,0,1,0);
        // Fatal on ch2 together with i_done -> FAIL
        add(1,1,0,0,4'h0,4'h0,8'h00, 1,0,0,0,0,0,0,0,0);
        add(1,0,0,1,4'h4,4'h0,8'h30, 3,0,0,0,1,0,2,1,1);
        add(1,0,1,0,4'h0,4'h0,8'h00, 0,0,0,0,1,0,2,1,0);
        // Watchdog expiry in RUN cycle 8
        add(1,1,0,0,4'h0,4'h0,8'h00, 1,0,0,0,0,0,0,0,0);
        for (int i = 0; i < TO - 1; i++) add(1,0,0,0,4'h0,4'h0,8'h00, 1,0,0,0,0,0,0,0,0);
        add(1,0,0,0,4'h0,4'h0,8'h00, 3,0,0,0,0,1,0,0,1);
        add(1,0,0,0,4'h0,4'h0,8'h00, 3,0,0,0,0,1,0,0,0);
        add(1,0,1,0,4'h0,4'h0,8'h00, 0,0,0,0,0,1,0,0,0);
        // i_done in RUN cycle 8 beats the watchdog
        add(1,1,0,0,4'h0,4'h0,8'h00, 1,0,0,0,0,0,0,0,0);
        for (int i = 0; i < TO - 1; i++) add(1,0,0,0,4'h0,4'h0,8'h00, 1,0,0,0,0,0,0,0,0);
        add(1,0,0,1,4'h0,4'h0,8'h00, 2,0,0,0,0,0,0,0,1);
        add(1,0,1,0,4'h0,4'h0,8'h00, 0,0,0,0,0,0,0,0,0);
        // Warn saturation (1, +2, +2 -> 3); i_start in RUN ignored
        add(1,1,0,0,4'h0,4'h0,8'h00, 1,0,0,0,0,0,0,0,0);
        add(1,0,0,0,4'h4,4'h0,8'h10, 1,0,1,0,0,0,2,1,0);
        add(1,1,0,0,4'h3,4'h0,8'h05, 1,0,3,0,0,0,2,1,0);
        add(1,0,0,0,4'hA,4'h0,8'h44, 1,0,3,0,0,0,2,1,0);
        // Reset mid-run: IDLE, everything zero, no finish
        add(0,0,0,0,4'h0,4'h0,8'h00, 0,0,0,0,0,0,0,0,0);
        add(0,1,0,0,4'h0,4'h0,8'h00, 0,0,0,0,0,0,0,0,0);
        add(1,0,0,0,4'h0,4'h0,8'h00, 0,0,0,0,0,0,0,0,0);
        // Error below limit then i_done -> FAIL; i_clear in RUN ignored
        add(1,1,0,0,4'h0,4'h0,8'h00, 1,0,0,0,0,0,0,0,0);
        add(1,0,1,0,4'h9,4'h1,8'h82, 1,0,0,1,0,0,3,1,0);
        add(1,0,0,1,4'h0,4'h0,8'h00, 3,0,0,1,0,0,3,1,1);
        add(1,0,1,0,4'h0,4'h0,8'h00, 0,0,0,1,0,0,3,1,0);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Watchdog latency measured with a bounded wait for o_finish
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("wd start state", 32'(state), 32'(ST_RUN));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (fin !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wd finish latency", n, TO);
        check("wd end state", 32'(state), 32'(ST_FAIL));
        check("wd timeout flag", 32'(tout), 1);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("wd clear state", 32'(state), 32'(ST_IDLE));
        clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/check_monitor.md
# check_monitor

Parametrised self-checking monitor for simulation testbenches and on-chip built-in self-test. It collects per-cycle check results from NUM_CH independent checker channels, each tagged with a severity (info, warning, error, fatal), and counts failures per severity with saturation. A run state machine decides pass/fail, applies an error limit and a timeout watchdog, and emits a single finish pulse. It sits between DUT-side checkers and the bench's end-of-test logic.

## Interface
Parameters:
- NUM_CH, 4: number of check channels (1..32)
- CNT_WIDTH, 16: width of each severity counter
- ERR_LIMIT, 1: error-severity failure count that forces FAIL (1..2^CNT_WIDTH-1)
- TIMEOUT, 1000: RUN cycles before watchdog FAIL; 0 disables the watchdog
- TO_WIDTH, $clog2(TIMEOUT+1): watchdog counter width

Ports (one clock; reset synchronous, active-low):
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-low reset
- i_start  input  1  begin a run; honoured only in IDLE
- i_clear  input  1  return from PASS/FAIL to IDLE
- i_done  input  1  stimulus complete; honoured only in RUN
- i_chk_valid  input  NUM_CH  per-channel check strobe
- i_chk_pass  input  NUM_CH  per-channel result, 1 = pass
- i_chk_sev  input  NUM_CH x 2  per-channel severity: 0 info, 1 warning, 2 error, 3 fatal
- o_state  output  2  IDLE=0, RUN=1, PASS=2, FAIL=3
- o_info_cnt, o_warn_cnt, o_err_cnt  output  CNT_WIDTH  failure counts per severity
- o_fatal  output  1  a fatal failure occurred this run
- o_timeout  output  1  the watchdog expired this run
- o_first_ch  output  $clog2(NUM_CH) (minimum 1)  channel of the first failure
- o_first_vld  output  1  o_first_ch is valid
- o_finish  output  1  one-cycle pulse on entering PASS or FAIL

## Operation
- Reset: state IDLE; all counters, flags, o_first_ch, o_first_vld and o_finish are 0.
- IDLE -> RUN on i_start. That same edge clears the counters, flags, first-fail capture and watchdog.
- A failure is i_chk_valid[c] & ~i_chk_pass[c]. Failures are counted only in RUN; all other states ignore them.
- Each severity counter adds the popcount of failing channels carrying that severity in the cycle. Counters saturate at all-ones with no wrap.
- First failure: the lowest-indexed failing channel of the earliest failing cycle is latched, and o_first_vld is set. Later failures do not change it.
- RUN -> FAIL when any of these holds, evaluated on the current cycle's inputs plus the registered counts:
  - a fatal failure is present;
  - the updated error count is >= ERR_LIMIT;
  - the watchdog reaches TIMEOUT.
- RUN -> PASS on i_done, provided the updated error count is 0 and no fatal failure is present. Otherwise i_done leads to FAIL.
- Priority: fatal/error-limit > i_done > timeout. If i_done and watchdog expiry occur in the same cycle, the i_done evaluation wins and o_timeout stays 0.
- Checks presented in the i_done cycle are counted.
- PASS/FAIL -> IDLE on i_clear. Counters and flags hold until the next i_start.
- i_start outside IDLE is ignored. i_clear outside PASS/FAIL is ignored.
- Warnings and infos never cause FAIL.

## Timing
- All outputs are registered.
- Counter, flag and state updates are visible one cycle after the triggering input edge.
- o_finish is high for exactly the first cycle in which o_state is PASS or FAIL.
- Watchdog:
  - counts RUN cycles starting at 1 in the first RUN cycle;
  - expiry causes FAIL in RUN cycle TIMEOUT, i.e. o_state = FAIL TIMEOUT+1 cycles after the i_start edge.
- Reset asserted mid-run: the next edge forces IDLE and clears everything. No o_finish pulse is produced.

## Structure
- Package check_monitor_pkg holds:
  - severity enum (SEV_INFO, SEV_WARN, SEV_ERROR, SEV_FATAL);
  - state enum (ST_IDLE, ST_RUN, ST_PASS, ST_FAIL);
  - the FAIL-cause priority constants.
- Sub-module check_sat_counter, instantiated three times:
  - parameters: input vector width and CNT_WIDTH;
  - behaviour: popcount of a masked failure vector, saturating add, synchronous clear.

## Test plan
- NUM_CH=4: start; ch1 warn-fail and ch3 info-fail in one cycle; i_done two cycles later -> PASS, warn=1, info=1, err=0, o_first_ch=1, o_finish pulses once.
- ERR_LIMIT=3: error failures on ch0 and ch2 in one cycle, then on ch1 -> err=3, FAIL on the second failure cycle, o_first_ch=0.
- Fatal failure on ch2 together with i_done -> FAIL, o_fatal=1, counters unchanged except fatal.
- TIMEOUT=8, no i_done -> o_state=FAIL 9 cycles after start, o_timeout=1. Repeat with i_done in RUN cycle 8 -> PASS, o_timeout=0.
- CNT_WIDTH=2: five warn failures -> warn saturates at 3. Reset mid-run -> IDLE, all outputs 0, no o_finish pulse.
- Failures injected in IDLE and PASS are ignored; i_start in PASS is ignored; i_clear then i_start clears all counters.
